// File: rtl/sorted_key_lookup_pkg.sv
// Shared types for the sorted key lookup responder: FSM state and CPU operation encodings.
package sorted_key_lookup_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    CPU  = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } cpu_op_e;

endpackage

// File: rtl/sorted_key_table.sv
// Lookup table storage: one synchronous write port, one asynchronous read port,
// and a dedicated word-0 output used for the never-taken match check.
module sorted_key_table #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 1024,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] word0_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately unreset so a loaded table survives Rst_n.
  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign word0_o = mem_q[0];

endmodule

// File: rtl/sorted_key_lookup.sv
// Fixed-latency floor search over a software-loaded sorted table, sharing its
// single read path between the search engine and CPU register accesses.
module sorted_key_lookup
  import sorted_key_lookup_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 1024,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [AW-1:0]         cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_access_done,
  input  logic [DATA_WIDTH-1:0] request_key,
  input  logic                  request_key_valid,
  output logic                  request_ready,
  output logic                  request_dropped,
  output logic [AW-1:0]         response_index,
  output logic                  response_valid,
  output logic                  no_match_found
);

  localparam logic [AW-1:0] TOP_BIT = AW'(1) << (AW - 1);

  state_e                state_q, state_d;
  logic                  pend_q, pend_d;
  cpu_op_e               op_q, op_d;
  logic [AW-1:0]         caddr_q, caddr_d;
  logic [DATA_WIDTH-1:0] cdata_q, cdata_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [AW-1:0]         idx_q, idx_d, mask_q, mask_d;
  logic                  eq_q, eq_d, tev_q, tev_d;
  logic                  ready_q, ready_d, drop_q, drop_d;
  logic [AW-1:0]         ridx_q, ridx_d;
  logic                  rvalid_q, rvalid_d, nomatch_q, nomatch_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  done_q, done_d;

  logic                  accept_s, in_step_s, search_s, new_cpu_s, service_s;
  logic                  taken_s, eq_nxt_s, tev_nxt_s, we_s;
  logic [AW-1:0]         mask_cur_s, idx_cur_s, probe_addr_s, idx_nxt_s, raddr_s, eff_addr_s;
  logic [DATA_WIDTH-1:0] key_cur_s, rdata_s, word0_s, eff_data_s;
  cpu_op_e               eff_op_s;

  assign accept_s  = request_key_valid && ready_q;
  assign in_step_s = (state_q == STEP);
  assign search_s  = accept_s || in_step_s;
  assign new_cpu_s = !pend_q && (cpu_wr || cpu_rd);
  assign service_s = (state_q == CPU) || ((state_q == IDLE) && !accept_s && (pend_q || new_cpu_s));

  // A fresh pulse can be serviced on the edge it arrives; write wins a tie.
  assign eff_op_s   = pend_q ? op_q : (cpu_wr ? OP_WR : OP_RD);
  assign eff_addr_s = pend_q ? caddr_q : cpu_addr;
  assign eff_data_s = pend_q ? cdata_q : cpu_data;

  assign mask_cur_s   = in_step_s ? mask_q : TOP_BIT;
  assign idx_cur_s    = in_step_s ? idx_q : {AW{1'b0}};
  assign key_cur_s    = in_step_s ? key_q : request_key;
  assign probe_addr_s = idx_cur_s | mask_cur_s;
  assign raddr_s      = search_s ? probe_addr_s : eff_addr_s;
  assign we_s         = service_s && (eff_op_s == OP_WR);

  assign taken_s   = (rdata_s <= key_cur_s);
  assign idx_nxt_s = taken_s ? probe_addr_s : idx_cur_s;
  assign eq_nxt_s  = taken_s ? (rdata_s == key_cur_s) : (in_step_s && eq_q);
  assign tev_nxt_s = taken_s || (in_step_s && tev_q);

  sorted_key_table #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_table (
    .Clk     (Clk),
    .we_i    (we_s),
    .waddr_i (eff_addr_s),
    .wdata_i (eff_data_s),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s),
    .word0_o (word0_s)
  );

  // Next-state: search stepping, CPU latch/service arbitration, output pulses.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    op_d      = op_q;
    caddr_d   = caddr_q;
    cdata_d   = cdata_q;
    key_d     = key_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    eq_d      = eq_q;
    tev_d     = tev_q;
    ridx_d    = ridx_q;
    rvalid_d  = 1'b0;
    nomatch_d = 1'b0;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    drop_d    = request_key_valid && !ready_q;

    if (service_s) begin
      pend_d  = 1'b0;
      done_d  = 1'b1;
      state_d = IDLE;
      if (eff_op_s == OP_RD) begin
        rd_data_d = rdata_s;
      end else begin
        rd_data_d = rd_data_q;
      end
    end else if (new_cpu_s) begin
      pend_d  = 1'b1;
      op_d    = cpu_wr ? OP_WR : OP_RD;
      caddr_d = cpu_addr;
      cdata_d = cpu_data;
    end else begin
      pend_d = pend_q;
    end

    if (search_s) begin
      key_d = key_cur_s;
      idx_d = idx_nxt_s;
      eq_d  = eq_nxt_s;
      tev_d = tev_nxt_s;
      if (mask_cur_s[0]) begin
        rvalid_d  = 1'b1;
        ridx_d    = idx_nxt_s;
        nomatch_d = !(tev_nxt_s ? eq_nxt_s : (word0_s == key_cur_s));
        state_d   = (pend_q || new_cpu_s) ? CPU : IDLE;
        mask_d    = mask_q;
      end else begin
        mask_d  = mask_cur_s >> 1;
        state_d = STEP;
      end
    end else begin
      mask_d = mask_q;
    end

    ready_d = (state_d == IDLE) && !pend_d;
  end

  // State and registered outputs; table contents are held in the sub-module.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      op_q      <= OP_RD;
      caddr_q   <= {AW{1'b0}};
      cdata_q   <= {DATA_WIDTH{1'b0}};
      key_q     <= {DATA_WIDTH{1'b0}};
      idx_q     <= {AW{1'b0}};
      mask_q    <= {AW{1'b0}};
      eq_q      <= 1'b0;
      tev_q     <= 1'b0;
      ready_q   <= 1'b0;
      drop_q    <= 1'b0;
      ridx_q    <= {AW{1'b0}};
      rvalid_q  <= 1'b0;
      nomatch_q <= 1'b0;
      rd_data_q <= {DATA_WIDTH{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      op_q      <= op_d;
      caddr_q   <= caddr_d;
      cdata_q   <= cdata_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      eq_q      <= eq_d;
      tev_q     <= tev_d;
      ready_q   <= ready_d;
      drop_q    <= drop_d;
      ridx_q    <= ridx_d;
      rvalid_q  <= rvalid_d;
      nomatch_q <= nomatch_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
    end
  end

  assign request_ready   = ready_q;
  assign request_dropped = drop_q;
  assign response_index  = ridx_q;
  assign response_valid  = rvalid_q;
  assign no_match_found  = nomatch_q;
  assign cpu_rd_data     = rd_data_q;
  assign cpu_access_done = done_q;

endmodule

// File: tb/tb_sorted_key_lookup.sv
// Directed bench for sorted_key_lookup at DATA_WIDTH=8, DEPTH=8.
module tb_sorted_key_lookup;

  localparam int DW = 8;
  localparam int DEP = 8;
  localparam int AW = 3;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_wr = 1'b0;
  logic          cpu_rd = 1'b0;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_access_done;
  logic [DW-1:0] request_key = '0;
  logic          request_key_valid = 1'b0;
  logic          request_ready;
  logic          request_dropped;
  logic [AW-1:0] response_index;
  logic          response_valid;
  logic          no_match_found;

  sorted_key_lookup #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .cpu_addr          (cpu_addr),
    .cpu_data          (cpu_data),
    .cpu_wr            (cpu_wr),
    .cpu_rd            (cpu_rd),
    .cpu_rd_data       (cpu_rd_data),
    .cpu_access_done   (cpu_access_done),
    .request_key       (request_key),
    .request_key_valid (request_key_valid),
    .request_ready     (request_ready),
    .request_dropped   (request_dropped),
    .response_index    (response_index),
    .response_valid    (response_valid),
    .no_match_found    (no_match_found)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  typedef logic [DW-1:0] tbl_t [DEP];
  typedef struct {
    logic [DW-1:0] key;
    logic [AW-1:0] idx;
    logic          nm;
  } vec_t;

  vec_t vecs [8];
  tbl_t tbl_lin;
  tbl_t tbl_dup;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cpu_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW-1:0] exp_rd);
    @(negedge Clk);
    cpu_wr = wr; cpu_rd = !wr; cpu_addr = addr; cpu_data = data;
    @(posedge Clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    check(wr ? "wr_done" : "rd_done", 32'(cpu_access_done), 32'd1);
    if (!wr) check("rd_data", 32'(cpu_rd_data), 32'(exp_rd));
    @(posedge Clk); #1;
    check("done_one_cycle", 32'(cpu_access_done), 32'd0);
  endtask

  task automatic load_table(input tbl_t t);
    for (int i = 0; i < DEP; i++) begin
      cpu_access(1'b1, AW'(i), t[i], 8'd0);
    end
  endtask

  task automatic search(input string name, input logic [DW-1:0] key,
                        input logic [AW-1:0] exp_idx, input logic exp_nm);
    int n;
    logic got;
    @(negedge Clk);
    check({name, "_ready"}, 32'(request_ready), 32'd1);
    request_key = key; request_key_valid = 1'b1;
    @(posedge Clk); #1;
    request_key_valid = 1'b0;
    n = 0; got = 1'b0;
    while (n < 8 && !got) begin
      @(posedge Clk); #1;
      n++;
      if (response_valid) got = 1'b1;
    end
    if (!got) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_latency"}, 32'(n), 32'(AW - 1));
      check({name, "_idx"}, 32'(response_index), 32'(exp_idx));
      check({name, "_nomatch"}, 32'(no_match_found), 32'(exp_nm));
    end
  endtask

  initial begin
    logic [DW-1:0] b2b_key [3];
    logic [AW-1:0] b2b_idx [3];
    logic          b2b_nm [3];
    logic          seen;

    for (int i = 0; i < DEP; i++) tbl_lin[i] = DW'((i + 1) * 10);
    tbl_dup[0] = 8'd10; tbl_dup[1] = 8'd20; tbl_dup[2] = 8'd20; tbl_dup[3] = 8'd20;
    tbl_dup[4] = 8'd30; tbl_dup[5] = 8'd40; tbl_dup[6] = 8'd50; tbl_dup[7] = 8'd60;
    vecs[0] = '{8'd50, 3'd4, 1'b0};
    vecs[1] = '{8'd10, 3'd0, 1'b0};
    vecs[2] = '{8'd80, 3'd7, 1'b0};
    vecs[3] = '{8'd55, 3'd4, 1'b1};
    vecs[4] = '{8'd5, 3'd0, 1'b1};
    vecs[5] = '{8'd200, 3'd7, 1'b1};
    vecs[6] = '{8'd35, 3'd2, 1'b1};
    vecs[7] = '{8'd79, 3'd6, 1'b1};
    b2b_key[0] = 8'd30; b2b_idx[0] = 3'd2; b2b_nm[0] = 1'b0;
    b2b_key[1] = 8'd45; b2b_idx[1] = 3'd3; b2b_nm[1] = 1'b1;
    b2b_key[2] = 8'd70; b2b_idx[2] = 3'd6; b2b_nm[2] = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ready", 32'(request_ready), 32'd0);
    check("rst_rvalid", 32'(response_valid), 32'd0);
    check("rst_done", 32'(cpu_access_done), 32'd0);
    check("rst_idx", 32'(response_index), 32'd0);
    check("rst_rd_data", 32'(cpu_rd_data), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1 check("ready_before_edge", 32'(request_ready), 32'd0);
    @(posedge Clk); #1;
    check("ready_after_release", 32'(request_ready), 32'd1);

    // Load and read back
    load_table(tbl_lin);
    cpu_access(1'b0, 3'd5, 8'd0, 8'd60);

    for (int i = 0; i < 8; i++) begin
      search($sformatf("vec%0d", i), vecs[i].key, vecs[i].idx, vecs[i].nm);
    end

    // Duplicates return the highest index of the run
    load_table(tbl_dup);
    search("dup20", 8'd20, 3'd3, 1'b0);
    load_table(tbl_lin);

    // Back-to-back: each new request accepted in the previous response cycle
    @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      check("b2b_ready", 32'(request_ready), 32'd1);
      request_key = b2b_key[k]; request_key_valid = 1'b1;
      @(posedge Clk); #1;
      request_key_valid = 1'b0;
      check("b2b_no_dup_resp", 32'(response_valid), 32'd0);
      repeat (2) @(posedge Clk);
      #1;
      check("b2b_rvalid", 32'(response_valid), 32'd1);
      check("b2b_idx", 32'(response_index), 32'(b2b_idx[k]));
      check("b2b_nomatch", 32'(no_match_found), 32'(b2b_nm[k]));
      @(negedge Clk);
    end
    seen = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
      seen = seen | response_valid;
    end
    check("b2b_no_extra", 32'(seen), 32'd0);

    // CPU write lands mid-search: serviced only after the response
    @(negedge Clk);
    request_key = 8'd50; request_key_valid = 1'b1;
    @(posedge Clk); #1;
    request_key_valid = 1'b0;
    @(negedge Clk);
    cpu_wr = 1'b1; cpu_addr = 3'd2; cpu_data = 8'd25;
    @(posedge Clk); #1;
    cpu_wr = 1'b0;
    check("busy_done_early", 32'(cpu_access_done), 32'd0);
    @(posedge Clk); #1;
    check("busy_rvalid", 32'(response_valid), 32'd1);
    check("busy_idx", 32'(response_index), 32'd4);
    check("busy_done_with_resp", 32'(cpu_access_done), 32'd0);
    check("busy_ready_low", 32'(request_ready), 32'd0);
    @(negedge Clk);
    request_key = 8'd25; request_key_valid = 1'b1;
    @(posedge Clk); #1;
    request_key_valid = 1'b0;
    check("busy_done", 32'(cpu_access_done), 32'd1);
    check("drop_pulse", 32'(request_dropped), 32'd1);
    seen = 1'b0;
    repeat (5) begin
      @(posedge Clk); #1;
      seen = seen | response_valid;
    end
    check("drop_no_resp", 32'(seen), 32'd0);
    search("after_wr25", 8'd25, 3'd2, 1'b0);

    // Reset mid-search aborts, table survives
    @(negedge Clk);
    request_key = 8'd50; request_key_valid = 1'b1;
    @(posedge Clk); #1;
    request_key_valid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(request_ready), 32'd0);
    check("midrst_rvalid", 32'(response_valid), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge Clk); #1;
      seen = seen | response_valid | cpu_access_done;
    end
    check("midrst_no_resp", 32'(seen), 32'd0);
    search("retained50", 8'd50, 3'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
